hkr_mem_arbiter: RTL and testbench

HKR_MEM_ARBITER -- requirements
Module: hkr_mem_arbiter

---
 rtl/hkr_mem_arbiter_if.sv | 44 ++++
 rtl/hkr_mem_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_hkr_mem_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hkr_mem_arbiter_if.sv
// Signal bundle for the fetch/data memory arbiter: two requester ports and the shared bus.
// The master modport is the arbiter's view; slave is the requesters' and bus slave's view.
interface hkr_mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        if_err;

  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        d_err;

  logic        bus_req;
  logic        bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    input  if_req, if_addr,
    output if_rdata, if_ack, if_err,
    input  d_req, d_we, d_be, d_addr, d_wdata,
    output d_rdata, d_ack, d_err,
    output bus_req, bus_we, bus_be, bus_addr, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    output if_req, if_addr,
    input  if_rdata, if_ack, if_err,
    output d_req, d_we, d_be, d_addr, d_wdata,
    input  d_rdata, d_ack, d_err,
    input  bus_req, bus_we, bus_be, bus_addr, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/hkr_mem_arbiter.sv
// Arbitrates instruction-fetch and data requests onto one memory bus, one transaction at a time,
// with a data-priority scheme bounded by a fetch-fairness streak and a per-transaction timeout.
module hkr_mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned FAIR_LIMIT     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  hkr_mem_arbiter_if.master mif
);

  localparam logic [3:0] STREAK_MAX = 4'(FAIR_LIMIT);
  localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  streak, streak_nxt;
  logic [7:0]  wait_cnt, wait_nxt;

  logic        if_ack_r, if_ack_nxt;
  logic        if_err_r, if_err_nxt;
  logic [31:0] if_rdata_r, if_rdata_nxt;
  logic        d_ack_r, d_ack_nxt;
  logic        d_err_r, d_err_nxt;
  logic [31:0] d_rdata_r, d_rdata_nxt;

  logic        bus_req_r, bus_req_nxt;
  logic        bus_we_r, bus_we_nxt;
  logic [3:0]  bus_be_r, bus_be_nxt;
  logic [31:0] bus_addr_r, bus_addr_nxt;
  logic [31:0] bus_wdata_r, bus_wdata_nxt;

  logic        fetch_forced;

  function automatic logic [3:0] streak_sat_inc(input logic [3:0] v);
    return (v >= STREAK_MAX) ? STREAK_MAX : v + 4'd1;
  endfunction

  function automatic logic wait_expired(input logic [7:0] cnt);
    return cnt == WAIT_LAST;
  endfunction

  // Data normally wins; once FAIR_LIMIT data grants have starved a waiting fetch, fetch goes next.
  assign fetch_forced = mif.if_req && (streak == STREAK_MAX);

  always_comb begin
    state_nxt     = state;
    streak_nxt    = streak;
    wait_nxt      = wait_cnt;
    if_ack_nxt    = 1'b0;
    if_err_nxt    = 1'b0;
    if_rdata_nxt  = if_rdata_r;
    d_ack_nxt     = 1'b0;
    d_err_nxt     = 1'b0;
    d_rdata_nxt   = d_rdata_r;
    bus_req_nxt   = bus_req_r;
    bus_we_nxt    = bus_we_r;
    bus_be_nxt    = bus_be_r;
    bus_addr_nxt  = bus_addr_r;
    bus_wdata_nxt = bus_wdata_r;

    case (state)
      IDLE: begin
        if (mif.d_req && !fetch_forced) begin
          state_nxt     = GRANT_D;
          wait_nxt      = 8'd0;
          bus_req_nxt   = 1'b1;
          bus_we_nxt    = mif.d_we;
          bus_be_nxt    = mif.d_be;
          bus_addr_nxt  = mif.d_addr;
          bus_wdata_nxt = mif.d_wdata;
          if (mif.if_req) begin
            streak_nxt = streak_sat_inc(streak);
          end
        end else if (mif.if_req) begin
          state_nxt     = GRANT_I;
          wait_nxt      = 8'd0;
          streak_nxt    = 4'd0;
          bus_req_nxt   = 1'b1;
          bus_we_nxt    = 1'b0;
          bus_be_nxt    = 4'hF;
          bus_addr_nxt  = mif.if_addr;
          bus_wdata_nxt = 32'd0;
        end
      end

      GRANT_I: begin
        // A bus_ack on the timeout edge still counts as a normal completion.
        if (mif.bus_ack) begin
          state_nxt    = IDLE;
          bus_req_nxt  = 1'b0;
          if_ack_nxt   = 1'b1;
          if_rdata_nxt = mif.bus_rdata;
        end else if (wait_expired(wait_cnt)) begin
          state_nxt    = IDLE;
          bus_req_nxt  = 1'b0;
          if_ack_nxt   = 1'b1;
          if_err_nxt   = 1'b1;
          if_rdata_nxt = 32'd0;
        end else begin
          wait_nxt = wait_cnt + 8'd1;
        end
      end

      GRANT_D: begin
        if (mif.bus_ack) begin
          state_nxt   = IDLE;
          bus_req_nxt = 1'b0;
          d_ack_nxt   = 1'b1;
          if (!bus_we_r) begin
            d_rdata_nxt = mif.bus_rdata;
          end
        end else if (wait_expired(wait_cnt)) begin
          state_nxt   = IDLE;
          bus_req_nxt = 1'b0;
          d_ack_nxt   = 1'b1;
          d_err_nxt   = 1'b1;
          if (!bus_we_r) begin
            d_rdata_nxt = 32'd0;
          end
        end else begin
          wait_nxt = wait_cnt + 8'd1;
        end
      end

      default: begin
        state_nxt   = IDLE;
        bus_req_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      streak      <= 4'd0;
      wait_cnt    <= 8'd0;
      if_ack_r    <= 1'b0;
      if_err_r    <= 1'b0;
      if_rdata_r  <= 32'd0;
      d_ack_r     <= 1'b0;
      d_err_r     <= 1'b0;
      d_rdata_r   <= 32'd0;
      bus_req_r   <= 1'b0;
      bus_we_r    <= 1'b0;
      bus_be_r    <= 4'd0;
      bus_addr_r  <= 32'd0;
      bus_wdata_r <= 32'd0;
    end else begin
      state       <= state_nxt;
      streak      <= streak_nxt;
      wait_cnt    <= wait_nxt;
      if_ack_r    <= if_ack_nxt;
      if_err_r    <= if_err_nxt;
      if_rdata_r  <= if_rdata_nxt;
      d_ack_r     <= d_ack_nxt;
      d_err_r     <= d_err_nxt;
      d_rdata_r   <= d_rdata_nxt;
      bus_req_r   <= bus_req_nxt;
      bus_we_r    <= bus_we_nxt;
      bus_be_r    <= bus_be_nxt;
      bus_addr_r  <= bus_addr_nxt;
      bus_wdata_r <= bus_wdata_nxt;
    end
  end

  assign mif.if_ack    = if_ack_r;
  assign mif.if_err    = if_err_r;
  assign mif.if_rdata  = if_rdata_r;
  assign mif.d_ack     = d_ack_r;
  assign mif.d_err     = d_err_r;
  assign mif.d_rdata   = d_rdata_r;
  assign mif.bus_req   = bus_req_r;
  assign mif.bus_we    = bus_we_r;
  assign mif.bus_be    = bus_be_r;
  assign mif.bus_addr  = bus_addr_r;
  assign mif.bus_wdata = bus_wdata_r;

endmodule

// File: tb/tb_hkr_mem_arbiter.sv
// Scoreboard bench for hkr_mem_arbiter: a bus-slave responder plus per-scenario tasks.
module tb_hkr_mem_arbiter;

  logic clk;
  logic rst_n;

  hkr_mem_arbiter_if mif ();

  hkr_mem_arbiter #(
    .TIMEOUT_CYCLES(64),
    .FAIR_LIMIT    (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .mif  (mif)
  );

  typedef struct packed {
    logic        is_d;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Bus-slave responder controls (written by tasks at negedge, used 2 time units after posedge).
  bit          resp_en       = 1'b1;
  bit          resp_force    = 1'b0;
  bit          resp_use_addr = 1'b0;
  int          resp_lat      = 0;
  logic [31:0] resp_data     = 32'd0;
  int          resp_cnt      = 0;
  logic [31:0] model_d_rdata = 32'd0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    mif.bus_ack   = 1'b0;
    mif.bus_rdata = 32'd0;
  end

  always @(posedge clk) begin
    #2;
    if (!resp_en) begin
      mif.bus_ack   = resp_force;
      mif.bus_rdata = resp_data;
      resp_cnt      = 0;
    end else if (mif.bus_req) begin
      if (resp_cnt >= resp_lat) begin
        mif.bus_ack   = 1'b1;
        mif.bus_rdata = resp_use_addr ? (mif.bus_addr ^ 32'h5A5A_0000) : resp_data;
        resp_cnt      = 0;
      end else begin
        mif.bus_ack   = 1'b0;
        mif.bus_rdata = 32'hBAD0_BAD0;
        resp_cnt++;
      end
    end else begin
      mif.bus_ack = 1'b0;
      resp_cnt    = 0;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, checks passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

  task automatic wait_ack(input int budget, output bit got, output bit got_d,
                          output logic [31:0] rd, output logic er, output bit both);
    int cyc;
    got = 1'b0; got_d = 1'b0; rd = 32'd0; er = 1'b0; both = 1'b0; cyc = 0;
    while (!got && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (mif.if_ack && mif.d_ack) both = 1'b1;
      if (mif.if_ack || mif.d_ack) begin
        got   = 1'b1;
        got_d = mif.d_ack;
        rd    = mif.d_ack ? mif.d_rdata : mif.if_rdata;
        er    = mif.d_ack ? mif.d_err : mif.if_err;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mif.if_req = 1'b0; mif.if_addr = 32'd0;
    mif.d_req = 1'b0; mif.d_we = 1'b0; mif.d_be = 4'd0; mif.d_addr = 32'd0; mif.d_wdata = 32'd0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({mif.bus_req, mif.if_ack, mif.d_ack, mif.if_err, mif.d_err} !== 5'b0)
      $display("FAIL reset_ctrl: got %b expected 00000",
               {mif.bus_req, mif.if_ack, mif.d_ack, mif.if_err, mif.d_err});
    else n_pass++;
    n_checks++;
    if ({mif.if_rdata, mif.d_rdata} !== 64'd0)
      $display("FAIL reset_rdata: got %h %h expected 0 0", mif.if_rdata, mif.d_rdata);
    else n_pass++;
    n_checks++;
    if ({mif.bus_we, mif.bus_be, mif.bus_addr, mif.bus_wdata} !== 69'd0)
      $display("FAIL reset_bus: got we=%b be=%h addr=%h wdata=%h expected all 0",
               mif.bus_we, mif.bus_be, mif.bus_addr, mif.bus_wdata);
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    exp_t e;
    resp_en = 1'b1; resp_lat = 0; resp_use_addr = 1'b0; resp_data = 32'hDEAD_BEEF;
    mif.d_req = 1'b1; mif.d_we = 1'b0; mif.d_be = 4'hF; mif.d_addr = 32'h100; mif.d_wdata = 32'd0;
    sb.push_back('{is_d: 1'b1, rdata: 32'hDEAD_BEEF, err: 1'b0});
    model_d_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    n_checks++;
    if ({mif.bus_req, mif.bus_we, mif.bus_addr, mif.d_ack} !== {1'b1, 1'b0, 32'h100, 1'b0})
      $display("FAIL rd_grant: got req=%b we=%b addr=%h ack=%b expected 1 0 00000100 0",
               mif.bus_req, mif.bus_we, mif.bus_addr, mif.d_ack);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (mif.d_ack !== 1'b1) $display("FAIL rd_latency: d_ack got %b expected 1 at N+2", mif.d_ack);
    else n_pass++;
    if (mif.d_ack === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      n_checks++;
      if ({mif.d_rdata, mif.d_err, mif.if_ack} !== {e.rdata, e.err, 1'b0})
        $display("FAIL rd_data: got %h err=%b if_ack=%b expected %h err=%b", mif.d_rdata, mif.d_err,
                 mif.if_ack, e.rdata, e.err);
      else n_pass++;
    end
    mif.d_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({mif.d_ack, mif.bus_req, mif.d_rdata} !== {1'b0, 1'b0, 32'hDEAD_BEEF})
      $display("FAIL rd_after: got ack=%b req=%b rdata=%h expected 0 0 deadbeef",
               mif.d_ack, mif.bus_req, mif.d_rdata);
    else n_pass++;
  endtask

  task automatic test_write();
    exp_t e;
    bit got;
    int ack_c;
    resp_en = 1'b1; resp_lat = 3; resp_use_addr = 1'b0; resp_data = 32'h5555_AAAA;
    mif.d_req = 1'b1; mif.d_we = 1'b1; mif.d_be = 4'b0011; mif.d_addr = 32'h40; mif.d_wdata = 32'h1234;
    sb.push_back('{is_d: 1'b1, rdata: model_d_rdata, err: 1'b0});
    got = 1'b0; ack_c = 0;
    for (int c = 1; c <= 12 && !got; c++) begin
      @(negedge clk);
      if (mif.d_ack) begin
        got = 1'b1; ack_c = c;
        mif.d_req = 1'b0;
        e = sb.pop_front();
        n_checks++;
        if ({mif.d_rdata, mif.d_err} !== {e.rdata, e.err})
          $display("FAIL wr_ack: got rdata=%h err=%b expected %h %b", mif.d_rdata, mif.d_err, e.rdata, e.err);
        else n_pass++;
      end else begin
        n_checks++;
        if ({mif.bus_req, mif.bus_we, mif.bus_be, mif.bus_addr, mif.bus_wdata} !==
            {1'b1, 1'b1, 4'b0011, 32'h40, 32'h1234})
          $display("FAIL wr_bus_hold: cycle %0d got req=%b we=%b be=%b addr=%h wdata=%h", c,
                   mif.bus_req, mif.bus_we, mif.bus_be, mif.bus_addr, mif.bus_wdata);
        else n_pass++;
        mif.d_wdata = 32'hFFFF_FFFF; mif.d_be = 4'hF; mif.d_addr = 32'd0;
      end
    end
    n_checks++;
    if (ack_c != resp_lat + 2) $display("FAIL wr_latency: ack at cycle %0d expected %0d", ack_c, resp_lat + 2);
    else n_pass++;
    if (!got) begin mif.d_req = 1'b0; void'(sb.pop_front()); end
    @(negedge clk);
  endtask

  task automatic test_drop_req();
    exp_t e;
    bit got, got_d, both;
    logic [31:0] rd;
    logic er;
    resp_en = 1'b1; resp_lat = 2; resp_use_addr = 1'b0; resp_data = 32'h0BAD_CAFE;
    mif.d_req = 1'b1; mif.d_we = 1'b0; mif.d_be = 4'hF; mif.d_addr = 32'h700;
    sb.push_back('{is_d: 1'b1, rdata: 32'h0BAD_CAFE, err: 1'b0});
    model_d_rdata = 32'h0BAD_CAFE;
    @(negedge clk);
    mif.d_req = 1'b0;
    wait_ack(10, got, got_d, rd, er, both);
    n_checks++;
    if (!got || !got_d) $display("FAIL drop_ack: got ack=%b d=%b expected d_ack pulse", got, got_d);
    else n_pass++;
    if (got) begin
      e = sb.pop_front();
      n_checks++;
      if ({rd, er} !== {e.rdata, e.err}) $display("FAIL drop_data: got %h err=%b expected %h", rd, er, e.rdata);
      else n_pass++;
    end else void'(sb.pop_front());
    @(negedge clk);
  endtask

  task automatic test_fairness();
    exp_t e;
    bit got, got_d, both;
    logic [31:0] rd;
    logic er;
    bit order[10];
    order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    resp_en = 1'b1; resp_lat = 0; resp_use_addr = 1'b1;
    for (int i = 0; i < 10; i++)
      sb.push_back('{is_d: order[i], rdata: (order[i] ? 32'h2000 : 32'h1000) ^ 32'h5A5A_0000, err: 1'b0});
    mif.if_req = 1'b1; mif.if_addr = 32'h1000;
    mif.d_req = 1'b1; mif.d_we = 1'b0; mif.d_be = 4'hF; mif.d_addr = 32'h2000; mif.d_wdata = 32'd0;
    for (int k = 0; k < 10; k++) begin
      wait_ack(8, got, got_d, rd, er, both);
      n_checks++;
      if (!got) begin
        $display("FAIL fair_timeout: no ack for grant %0d", k);
        break;
      end else n_pass++;
      e = sb.pop_front();
      n_checks++;
      if ({got_d, rd, er, both} !== {e.is_d, e.rdata, e.err, 1'b0})
        $display("FAIL fair_grant%0d: got d=%b rdata=%h err=%b both=%b expected d=%b rdata=%h", k,
                 got_d, rd, er, both, e.is_d, e.rdata);
      else n_pass++;
      if (k == 9) begin mif.if_req = 1'b0; mif.d_req = 1'b0; end
    end
    mif.if_req = 1'b0; mif.d_req = 1'b0;
    sb.delete();
    model_d_rdata = 32'h5A5A_2000;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    exp_t e;
    int rise_c, ack_c, req_cycles;
    resp_en = 1'b0; resp_force = 1'b0;
    mif.if_req = 1'b1; mif.if_addr = 32'h3000;
    sb.push_back('{is_d: 1'b0, rdata: 32'd0, err: 1'b1});
    rise_c = -1; ack_c = -1; req_cycles = 0;
    for (int c = 1; c <= 100 && ack_c < 0; c++) begin
      @(negedge clk);
      if (mif.bus_req) req_cycles++;
      if (rise_c < 0 && mif.bus_req) rise_c = c;
      if (mif.if_ack) begin
        ack_c = c;
        mif.if_req = 1'b0;
        e = sb.pop_front();
        n_checks++;
        if ({mif.if_rdata, mif.if_err, mif.bus_req, mif.d_ack} !== {e.rdata, e.err, 1'b0, 1'b0})
          $display("FAIL to_ack: got rdata=%h err=%b bus_req=%b d_ack=%b expected %h %b 0 0",
                   mif.if_rdata, mif.if_err, mif.bus_req, mif.d_ack, e.rdata, e.err);
        else n_pass++;
      end
    end
    n_checks++;
    if (ack_c - rise_c != 64 || rise_c < 0)
      $display("FAIL to_latency: ack %0d cycles after bus_req rose, expected 64", ack_c - rise_c);
    else n_pass++;
    n_checks++;
    if (req_cycles != 64) $display("FAIL to_busreq_len: bus_req high %0d cycles expected 64", req_cycles);
    else n_pass++;
    if (ack_c < 0) begin mif.if_req = 1'b0; sb.delete(); end
    @(negedge clk);
    n_checks++;
    if (mif.bus_req !== 1'b0 || mif.if_ack !== 1'b0)
      $display("FAIL to_after: got bus_req=%b if_ack=%b expected 0 0", mif.bus_req, mif.if_ack);
    else n_pass++;
    resp_en = 1'b1;
  endtask

  task automatic test_ack_on_timeout_edge();
    exp_t e;
    int ack_c;
    resp_en = 1'b1; resp_lat = 63; resp_use_addr = 1'b0; resp_data = 32'h1357_9BDF;
    mif.d_req = 1'b1; mif.d_we = 1'b0; mif.d_be = 4'hF; mif.d_addr = 32'h800;
    sb.push_back('{is_d: 1'b1, rdata: 32'h1357_9BDF, err: 1'b0});
    ack_c = -1;
    for (int c = 1; c <= 100 && ack_c < 0; c++) begin
      @(negedge clk);
      if (mif.d_ack) begin
        ack_c = c;
        mif.d_req = 1'b0;
        e = sb.pop_front();
        n_checks++;
        if ({mif.d_rdata, mif.d_err} !== {e.rdata, e.err})
          $display("FAIL edge_ack: got rdata=%h err=%b expected %h %b", mif.d_rdata, mif.d_err, e.rdata, e.err);
        else n_pass++;
      end
    end
    n_checks++;
    if (ack_c != 65) $display("FAIL edge_latency: d_ack at cycle %0d expected 65", ack_c);
    else n_pass++;
    if (ack_c < 0) begin mif.d_req = 1'b0; sb.delete(); end
    model_d_rdata = 32'h1357_9BDF;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    exp_t e;
    bit got, got_d, both;
    logic [31:0] rd;
    logic er;
    resp_en = 1'b0; resp_force = 1'b0; resp_data = 32'h7777_7777;
    mif.d_req = 1'b1; mif.d_we = 1'b0; mif.d_be = 4'hF; mif.d_addr = 32'h500;
    @(negedge clk);
    n_checks++;
    if (mif.bus_req !== 1'b1) $display("FAIL rm_grant: bus_req got %b expected 1", mif.bus_req);
    else n_pass++;
    rst_n = 1'b0; mif.d_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({mif.bus_req, mif.d_ack, mif.d_err, mif.d_rdata, mif.bus_addr, mif.if_rdata} !== 99'd0)
      $display("FAIL rm_reset: got req=%b ack=%b err=%b rdata=%h addr=%h if_rdata=%h expected all 0",
               mif.bus_req, mif.d_ack, mif.d_err, mif.d_rdata, mif.bus_addr, mif.if_rdata);
    else n_pass++;
    rst_n = 1'b1; resp_force = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      resp_force = 1'b0;
      n_checks++;
      if ({mif.d_ack, mif.if_ack, mif.bus_req, mif.d_rdata} !== 35'd0)
        $display("FAIL rm_late_ack: cycle %0d got d_ack=%b if_ack=%b req=%b rdata=%h expected 0", c,
                 mif.d_ack, mif.if_ack, mif.bus_req, mif.d_rdata);
      else n_pass++;
    end
    resp_en = 1'b1; resp_lat = 1; resp_use_addr = 1'b0; resp_data = 32'hCAFE_F00D;
    mif.d_req = 1'b1; mif.d_addr = 32'h600;
    sb.push_back('{is_d: 1'b1, rdata: 32'hCAFE_F00D, err: 1'b0});
    wait_ack(10, got, got_d, rd, er, both);
    mif.d_req = 1'b0;
    n_checks++;
    if (!got || !got_d) $display("FAIL rm_next: got ack=%b d=%b expected d_ack", got, got_d);
    else n_pass++;
    if (got) begin
      e = sb.pop_front();
      n_checks++;
      if ({rd, er} !== {e.rdata, e.err}) $display("FAIL rm_next_data: got %h err=%b expected %h", rd, er, e.rdata);
      else n_pass++;
    end else sb.delete();
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_drop_req();
    test_fairness();
    test_timeout();
    test_ack_on_timeout_edge();
    test_reset_mid();
    n_checks++;
    if (sb.size() != 0) $display("FAIL sb_empty: %0d expected entries left", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
